// File: rtl/fifo_rd_chk.sv
// fifo_rd_chk: drains the async test FIFO once full and checks words against an incrementing byte pattern.
// Define FIFO_RD_CHK_RESYNC_EN to realign the expected value to the received word after a mismatch.
module fifo_rd_chk #(
    parameter int DW     = 8,
    parameter int SETTLE = 3,
    parameter int ERR_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_full,
    input  logic             rd_empt,
    input  logic [DW-1:0]    rd_data,
    output logic             rd_req,
    output logic [ERR_W-1:0] err_cnt,
    output logic [31:0]      word_cnt,
    output logic [15:0]      burst_cnt,
    output logic             err_flag,
    output logic             busy
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_DRAIN  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             vld_q;
    logic [DW-1:0]    exp_q, exp_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [31:0]      word_q, word_d;
    logic [15:0]      burst_q, burst_d;
    logic             flag_q, flag_d;
    logic             mismatch;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:   state_d = S_WAIT;
            // empty wins over full while the FIFO is held in aclr
            S_WAIT: if (rd_full && !rd_empt) begin
                state_d = S_SETTLE;
                cnt_d   = 4'(SETTLE - 1);
            end
            S_SETTLE: if (cnt_q == 4'd0) state_d = S_DRAIN;
                      else cnt_d = cnt_q - 4'd1;
            default:  if (rd_empt) state_d = S_WAIT;
        endcase
        req_d    = (state_d == S_DRAIN) && !rd_empt;
        burst_d  = (state_q == S_DRAIN && rd_empt) ? burst_q + 16'd1 : burst_q;
        mismatch = vld_q && (rd_data != exp_q);
        word_d   = vld_q ? word_q + 32'd1 : word_q;
        err_d    = (mismatch && !(&err_q)) ? err_q + ERR_W'(1) : err_q;
        flag_d   = flag_q || mismatch;
`ifdef FIFO_RD_CHK_RESYNC_EN
        exp_d    = vld_q ? (mismatch ? rd_data : exp_q) + DW'(1) : exp_q;
`else
        exp_d    = vld_q ? exp_q + DW'(1) : exp_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= 1'b0;
            vld_q   <= 1'b0;
            exp_q   <= '0;
            err_q   <= '0;
            word_q  <= 32'd0;
            burst_q <= 16'd0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            vld_q   <= req_q;
            exp_q   <= exp_d;
            err_q   <= err_d;
            word_q  <= word_d;
            burst_q <= burst_d;
            flag_q  <= flag_d;
        end
    end

    assign rd_req    = req_q;
    assign err_cnt   = err_q;
    assign word_cnt  = word_q;
    assign burst_cnt = burst_q;
    assign err_flag  = flag_q;
    assign busy      = (state_q == S_SETTLE) || (state_q == S_DRAIN);
endmodule
